// File: rtl/rr_grant_arbiter_pkg.sv
// Shared definitions for the round-robin grant arbiter: sizes, FSM state
// encoding and the search-result record.
package rr_grant_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

endpackage

// File: rtl/rr_grant_arbiter_onehot_dec.sv
// Enable-gated 3-to-8 decoder that turns the registered owner index into the
// one-hot grant vector; a disabled decoder drives all zeros.
module onehot_dec_3to8 (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] y
);

  assign y = en ? (8'(1) << idx) : 8'h00;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for 8 requesters with grant locking and a hold counter
// that forces rotation once the owner has held the resource HOLD_MAX cycles.
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] others_req;
  pick_t            pick;

  // Scans start, start+1, ... start+7 (mod 8); iterating from the far end
  // lets the closest set bit overwrite earlier finds.
  function automatic pick_t rr_search(input logic [N_REQ-1:0] vec,
                                      input logic [IDX_W-1:0] start);
    pick_t            p;
    logic [IDX_W-1:0] cand;
    p = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = start + IDX_W'(i);
      if (vec[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

  // The owner never competes against itself when a rotation is considered.
  assign others_req = req & ~(N_REQ'(1) << idx_q);
  assign pick       = rr_search((state_q == ST_GRANT) ? others_req : req, ptr_q);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en && pick.found) begin
          state_d = ST_GRANT;
          idx_d   = pick.idx;
          ptr_d   = pick.idx + IDX_W'(1);
          cnt_d   = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (pick.found &&
                     (!req[idx_q] || cnt_q == CNT_W'(HOLD_MAX))) begin
          idx_d = pick.idx;
          ptr_d = pick.idx + IDX_W'(1);
          cnt_d = CNT_W'(1);
        end else if (!req[idx_q]) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != CNT_W'(HOLD_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_valid = (state_q == ST_GRANT);
  assign gnt_idx   = idx_q;

  onehot_dec_3to8 u_dec (
    .idx (idx_q),
    .en  (gnt_valid),
    .y   (gnt)
  );

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: vector table plus hand-written
// multi-cycle sequences, with expected grants queued as stimulus is driven.
module tb_rr_grant_arbiter;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [7:0] req   = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int checks = 0;
  int errors = 0;

  rr_grant_arbiter #(
    .HOLD_MAX (4),
    .CNT_W    (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [7:0] g;
    logic [2:0] i;
  } obs_t;

  typedef struct {
    logic [7:0] req;
    logic       en;
    logic       v;
    logic [2:0] idx;
    string      name;
  } vec_t;

  obs_t sb_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t mk(input logic v, input logic [2:0] i);
    obs_t o;
    o.v = v;
    o.g = v ? (8'h01 << i) : 8'h00;
    o.i = v ? i : 3'd0;
    return o;
  endfunction

  // Drive one cycle of inputs, queue the expected post-edge grant, then
  // compare it against the DUT just after the rising edge.
  task automatic step(input logic [7:0] r, input logic e, input logic ev,
                      input logic [2:0] ei, input string name);
    obs_t exp_o, act_o;
    req = r;
    en  = e;
    sb_q.push_back(mk(ev, ei));
    @(posedge clk);
    #1;
    exp_o   = sb_q.pop_front();
    act_o.v = gnt_valid;
    act_o.g = gnt;
    act_o.i = gnt_valid ? gnt_idx : 3'd0;
    check(name, 32'(act_o), 32'(exp_o));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("onehot0", 32'($onehot0(gnt)), 32'd1);
      check("valid_eq_or", 32'(gnt_valid), 32'(|gnt));
      if (gnt_valid) check("gnt_eq_idx", 32'(gnt), 32'(8'h01 << gnt_idx));
    end
  end

  initial begin
    // Reset held with every requester active: nothing may be granted.
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'h00);
    check("rst_valid", 32'(gnt_valid), 32'h0);
    check("rst_idx", 32'(gnt_idx), 32'h0);
    @(negedge clk);
    req   = 8'h01;
    rst_n = 1'b1;
    step(8'h01, 1'b1, 1'b1, 3'd0, "rst_release");
    step(8'h00, 1'b1, 1'b0, 3'd0, "release_idle");

    // Fresh reset so the pointer starts at 0 for the fairness sweep.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;

    vecs.push_back('{8'hFF, 1'b1, 1'b1, 3'd0, "fair"});
    for (int k = 1; k <= 8; k++)
      vecs.push_back('{~(8'h01 << (k - 1)), 1'b1, 1'b1, 3'(k % 8), "fair"});
    vecs.push_back('{8'h20, 1'b1, 1'b1, 3'd5, "wrap_setup"});
    vecs.push_back('{8'h41, 1'b1, 1'b1, 3'd6, "wrap_ptr6"});
    vecs.push_back('{8'h01, 1'b1, 1'b1, 3'd0, "wrap_to0"});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 3'd0, "wrap_idle"});
    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].req, vecs[i].en, vecs[i].v, vecs[i].idx, vecs[i].name);

    // Preempt after HOLD_MAX=4 cycles, then an uncontested owner keeps it.
    step(8'h04, 1'b1, 1'b1, 3'd2, "pre_grant");
    repeat (3) step(8'h24, 1'b1, 1'b1, 3'd2, "pre_hold");
    step(8'h24, 1'b1, 1'b1, 3'd5, "preempt");
    repeat (8) step(8'h20, 1'b1, 1'b1, 3'd5, "sole_hold");

    // Enable handling.
    step(8'h08, 1'b1, 1'b1, 3'd3, "gnt08");
    step(8'h08, 1'b0, 1'b0, 3'd0, "en_drop");
    repeat (3) step(8'hFF, 1'b0, 1'b0, 3'd0, "en_low_ff");
    step(8'hFF, 1'b1, 1'b1, 3'd4, "en_back");
    step(8'hFF, 1'b0, 1'b0, 3'd0, "en_wins");
    step(8'hFF, 1'b1, 1'b1, 3'd5, "en_regrant");

    // Asynchronous reset between edges must clear the grant immediately.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'h00);
    check("async_rst_valid", 32'(gnt_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h01, 1'b1, 1'b1, 3'd0, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
